// File: rtl/csel_addsub_pipe.sv
// rtl/csel_addsub_pipe.sv - two-stage carry-select 32-bit add/subtract pipe with valid/ready
// Stage 1 adds the low half and registers the mid carry; stage 2 selects the precomputed high half.
module csel_addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int H = WIDTH / 2;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [H:0]       lo_full;
  logic [H:0]       hi0;
  logic [H:0]       hi1;
  logic [H:0]       hi_sel;

  logic             s1_valid_q, s1_valid_d;
  logic [H-1:0]     lo_sum_q, lo_sum_d;
  logic             c_mid_q, c_mid_d;
  logic [H-1:0]     a_hi_q, a_hi_d;
  logic [H-1:0]     b_hi_q, b_hi_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    s2_adv = !out_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    accept = in_valid && s1_adv;

    // Subtract is A + ~B + ~Cin, so Cin acts as a borrow-in.
    b_eff   = Op ? ~B : B;
    c_eff   = Op ? ~Cin : Cin;
    lo_full = {1'b0, A[H-1:0]} + {1'b0, b_eff[H-1:0]} + {{H{1'b0}}, c_eff};

    s1_valid_d = s1_valid_q;
    lo_sum_d   = lo_sum_q;
    c_mid_d    = c_mid_q;
    a_hi_d     = a_hi_q;
    b_hi_d     = b_hi_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      lo_sum_d = lo_full[H-1:0];
      c_mid_d  = lo_full[H];
      a_hi_d   = A[WIDTH-1:H];
      b_hi_d   = b_eff[WIDTH-1:H];
    end

    hi0    = {1'b0, a_hi_q} + {1'b0, b_hi_q};
    hi1    = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{H{1'b0}}, 1'b1};
    hi_sel = c_mid_q ? hi1 : hi0;

    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    // Output data only moves when a real beat advances, so it stays still while idle.
    if (s2_adv && s1_valid_q) begin
      sum_d  = {hi_sel[H-1:0], lo_sum_q};
      cout_d = hi_sel[H];
      ovf_d  = (a_hi_q[H-1] == b_hi_q[H-1]) && (hi_sel[H-1] != a_hi_q[H-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      lo_sum_q    <= '0;
      c_mid_q     <= 1'b0;
      a_hi_q      <= '0;
      b_hi_q      <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      lo_sum_q    <= lo_sum_d;
      c_mid_q     <= c_mid_d;
      a_hi_q      <= a_hi_d;
      b_hi_q      <= b_hi_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_csel_addsub_pipe.sv
// tb/tb_csel_addsub_pipe.sv - bench for csel_addsub_pipe against an integer-arithmetic model
// Directed vectors, back-pressure, mid-flight reset and randomized traffic with random stalls.
module tb_csel_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Sum;
  logic        Cout;
  logic        Ovf;

  int vectors;
  int miscompares;

  csel_addsub_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Op(Op), .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {Cout, Ovf, Sum} from exact integer arithmetic.
  function automatic logic [33:0] model(input logic op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    longint ua, ub, sa, sb, r, ex;
    logic co, ov;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      r  = ua - ub - longint'(cin);
      co = (r >= 0);
      ex = sa - sb - longint'(cin);
    end else begin
      r  = ua + ub + longint'(cin);
      co = (r >= 64'sh1_0000_0000);
      ex = sa + sb + longint'(cin);
    end
    ov = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
    return {co, ov, r[31:0]};
  endfunction

  // Presents one beat to an empty pipe and reports edges until out_valid (0 on timeout).
  task automatic issue_single(input logic op, input logic [31:0] a, input logic [31:0] b,
                              input logic cin, output int lat, output logic [31:0] s,
                              output logic co, output logic ov);
    @(negedge clk);
    in_valid = 1'b1; Op = op; A = a; B = b; Cin = cin; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = 0;
    s = Sum; co = Cout; ov = Ovf;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, Sum, Cout, Ovf, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_state: got ov=%b sum=%h c=%b o=%b ir=%b want 0/0/0/0/1",
               out_valid, Sum, Cout, Ovf, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic        ops  [8];
    logic [31:0] as   [8];
    logic [31:0] bs   [8];
    logic        cins [8];
    logic [31:0] es   [8];
    logic        ecs  [8];
    logic        eos  [8];
    int lat; logic [31:0] s; logic co, ov;
    ops[0]=0; as[0]=32'h7FFFFFFF; bs[0]=32'h1;        cins[0]=0; es[0]=32'h80000000; ecs[0]=0; eos[0]=1;
    ops[1]=1; as[1]=32'h80000000; bs[1]=32'h1;        cins[1]=0; es[1]=32'h7FFFFFFF; ecs[1]=1; eos[1]=1;
    ops[2]=1; as[2]=32'd100;      bs[2]=32'd200;      cins[2]=0; es[2]=32'hFFFFFF9C; ecs[2]=0; eos[2]=0;
    ops[3]=0; as[3]=-32'sd50;     bs[3]=-32'sd100;    cins[3]=1; es[3]=32'hFFFFFF6B; ecs[3]=1; eos[3]=0;
    ops[4]=0; as[4]=32'h0000FFFF; bs[4]=32'h1;        cins[4]=0; es[4]=32'h00010000; ecs[4]=0; eos[4]=0;
    ops[5]=1; as[5]=32'h00010000; bs[5]=32'h1;        cins[5]=1; es[5]=32'h0000FFFE; ecs[5]=1; eos[5]=0;
    ops[6]=0; as[6]=32'hFFFFFFFF; bs[6]=32'h1;        cins[6]=0; es[6]=32'h0;        ecs[6]=1; eos[6]=0;
    ops[7]=1; as[7]=32'h0;        bs[7]=32'h0;        cins[7]=0; es[7]=32'h0;        ecs[7]=1; eos[7]=0;
    for (int i = 0; i < 8; i++) begin
      issue_single(ops[i], as[i], bs[i], cins[i], lat, s, co, ov);
      vectors++;
      if (lat !== 2) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d edges want 2", i, lat);
      end
      vectors++;
      if ({s, co, ov} !== {es[i], ecs[i], eos[i]}) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                 i, s, co, ov, es[i], ecs[i], eos[i]);
      end
    end
  endtask

  task automatic test_back_pressure;
    int sent, got, first_cyc;
    logic [31:0] exp_sum;
    sent = 0; got = 0; first_cyc = -1;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      Op = 1'b0; Cin = 1'b0;
      A = 32'(sent + 1); B = 32'(sent + 1);
      #1;
      if (cyc == 2) begin
        vectors++;
        if (in_ready !== 1'b0 || sent != 2) begin
          miscompares++;
          $display("FAIL bp_in_ready: got in_ready=%b after %0d accepts want 0 after 2", in_ready, sent);
        end
      end
      if (cyc >= 2 && cyc <= 4) begin
        vectors++;
        if ({out_valid, Sum} !== {1'b1, 32'd2}) begin
          miscompares++;
          $display("FAIL bp_hold: cycle %0d got v=%b sum=%h want v=1 sum=2", cyc, out_valid, Sum);
        end
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        exp_sum = 32'(2 * (got + 1));
        vectors++;
        if (Sum !== exp_sum || cyc != first_cyc + got) begin
          miscompares++;
          $display("FAIL bp_order: got sum=%h at cycle %0d want sum=%h at cycle %0d",
                   Sum, cyc, exp_sum, first_cyc + got);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results want 4", got);
    end
  endtask

  task automatic test_reset_mid;
    int lat, seen; logic [31:0] s; logic co, ov;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; Op = 1'b0; A = 32'd10; B = 32'd20; Cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    A = 32'd30; B = 32'd40;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: got out_valid=%b want 0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL mid_reset_ghost: got %0d stale results want 0", seen);
    end
    issue_single(1'b0, 32'd5, 32'd7, 1'b0, lat, s, co, ov);
    vectors++;
    if (lat !== 2 || s !== 32'd12) begin
      miscompares++;
      $display("FAIL mid_reset_first: got lat=%0d sum=%h want lat=2 sum=0000000c", lat, s);
    end
  endtask

  task automatic test_random;
    logic [33:0] q[$];
    logic [33:0] exp;
    logic        held;
    logic [33:0] held_val;
    logic        exp_ready;
    int accepted;
    accepted = 0; held = 1'b0; held_val = '0;
    for (int cyc = 0; cyc < 3000 && (accepted < 400 || q.size() != 0); cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (accepted < 400) && ($urandom_range(0, 3) != 0);
      Op = 1'($urandom); Cin = 1'($urandom);
      A = $urandom; B = $urandom;
      if ($urandom_range(0, 7) == 0) A = 32'h0000FFFF;
      if ($urandom_range(0, 7) == 0) B = 32'h80000000;
      #1;
      exp_ready = !(q.size() >= 2 && !out_ready);
      vectors++;
      if (in_ready !== exp_ready) begin
        miscompares++;
        $display("FAIL rand_in_ready: cycle %0d got %b want %b (in flight %0d)", cyc, in_ready, exp_ready, q.size());
      end
      if (held) begin
        vectors++;
        if ({out_valid, Cout, Ovf, Sum} !== {1'b1, held_val}) begin
          miscompares++;
          $display("FAIL rand_stall_hold: got v=%b %h want v=1 %h", out_valid, {Cout, Ovf, Sum}, held_val);
        end
      end
      if (out_valid && out_ready) begin
        exp = (q.size() != 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
        vectors++;
        if ({Cout, Ovf, Sum} !== exp) begin
          miscompares++;
          $display("FAIL rand_result: got c/o/sum=%h want %h", {Cout, Ovf, Sum}, exp);
        end
      end
      held = out_valid && !out_ready;
      held_val = {Cout, Ovf, Sum};
      if (in_valid && in_ready) begin
        q.push_back(model(Op, A, B, Cin));
        accepted++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (accepted != 400 || q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: got %0d accepted %0d pending want 400 accepted 0 pending", accepted, q.size());
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; Op = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_directed;
    test_back_pressure;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csel_addsub_pipe.md
# csel_addsub_pipe

Two-stage pipelined 32-bit two's-complement adder/subtractor built on a 16/16 carry-select split, with valid/ready handshakes on both sides and a signed-overflow flag. It is the sequential, subtract-capable counterpart of the combinational carry-select adder in the adder library. It sits between an operand producer and a result consumer, and sustains one operation per cycle under back-pressure.

## Interface
- `WIDTH`, 32: operand and result width. Must be even; the low and high halves are each `WIDTH/2`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block can accept a beat this cycle.
- `Op` input 1: 0 = add, 1 = subtract.
- `A` input WIDTH: operand A.
- `B` input WIDTH: operand B.
- `Cin` input 1: carry-in for add; borrow-in for subtract.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: consumer accepts the result.
- `Sum` output WIDTH: result.
- `Cout` output 1: carry-out. For subtract, 1 means no borrow.
- `Ovf` output 1: signed overflow.

## Operation
- Effective operands:
  - `Beff = Op ? ~B : B`
  - `Ceff = Op ? ~Cin : Cin`
  - Result is `{Cout,Sum} = A + Beff + Ceff` (WIDTH+1 bits).
  - Subtract therefore yields `A - B - Cin`.
- Stage 1 (on accept):
  - Compute the low-half sum and the carry into the high half, `c_mid`.
  - Register the low sum, `c_mid`, `A_hi`, `Beff_hi` and `s1_valid`.
- Stage 2:
  - Compute the high half twice, with carry-in 0 and with carry-in 1.
  - Select by the registered `c_mid`.
  - Register `Sum`, `Cout`, `Ovf` and `out_valid`.
- `Ovf = (A[MSB] == Beff[MSB]) && (Sum[MSB] != A[MSB])`, computed in stage 2 from the registered MSBs.
- Handshake:
  - A beat is accepted when `in_valid && in_ready`.
  - A result is consumed when `out_valid && out_ready`.
  - `s2_adv = !out_valid || out_ready`
  - `s1_adv = !s1_valid || s2_adv`
  - `in_ready = s1_adv` (combinational).
- Stall: while `out_valid && !out_ready`, `Sum`, `Cout` and `Ovf` hold bit-stable. Stage 1 holds if it is occupied.
- Ordering: results leave strictly in acceptance order. No drops, no duplicates.
- Data registers load only when their stage advances with valid data. Output data does not change while `out_valid` is 0, except at reset.

## Timing
- Latency: a beat accepted at edge N gives `out_valid` = 1 after edge N+2 when not stalled.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Capacity: 2 beats in flight. With `out_ready` low and both stages full, `in_ready` = 0 in the same cycle.
- Simultaneous consume and accept with the pipe full: both happen in the same cycle, and the pipe stays full.
- Reset (asynchronous, immediate):
  - `s1_valid`, `out_valid` = 0.
  - `Sum` = 0, `Cout` = 0, `Ovf` = 0.
  - Stage-1 data = 0.
  - `in_ready` = 1 after reset.
- Reset mid-operation: all in-flight beats are discarded and none are emitted after release. The first beat accepted after release gives its result 2 edges later.
- Wrap-around: `Sum` is modulo 2^WIDTH and the carry is reported on `Cout`. No saturation.
- Halves boundary: a carry out of bit `WIDTH/2-1` propagates correctly via the `c_mid` select.

## Test plan
- Add 0x7FFFFFFF + 0x00000001, `Cin`=0 → `Sum`=0x80000000, `Cout`=0, `Ovf`=1; `out_valid` 2 edges after accept.
- Sub 0x80000000 − 0x00000001, `Cin`=0 → `Sum`=0x7FFFFFFF, `Cout`=1, `Ovf`=1.
- Sub 100 − 200, `Cin`=0 → `Sum`=0xFFFFFF9C (−100), `Cout`=0, `Ovf`=0. Then add −50 + −100, `Cin`=1 → `Sum`=0xFFFFFF6B (−149), `Cout`=1, `Ovf`=0.
- Halves carry check:
  - Add 0x0000FFFF + 0x00000001, `Cin`=0 → `Sum`=0x00010000.
  - Sub 0x00010000 − 0x00000001, `Cin`=1 → `Sum`=0x0000FFFE, `Cout`=1.
- Back-pressure: stream 4 beats (1+1, 2+2, 3+3, 4+4) with `out_ready` low for 3 cycles.
  - `in_ready` drops after 2 accepts, and the first result (2) holds stable.
  - After release, results 2, 4, 6, 8 appear in order on consecutive cycles.
- Assert `rst` with 2 beats in flight → `out_valid` = 0 immediately, nothing emitted afterwards. A post-reset beat 5+7 → `Sum` = 12 after 2 edges.
